// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the shared 8-digit display, with a minimum dwell per owner and a switch override.
// Optional feature: define SEG_ARB_LOCK_EN to add the per-source lock port (hold grant at expiry).
module seg_display_arbiter #(
  parameter int unsigned       N_SRC      = 4,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       DWELL      = 50_000_000,
  parameter logic [DATA_W-1:0] IDLE_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        req,
  input  logic [N_SRC*DATA_W-1:0] data,
  input  logic                    force_en,
  input  logic [2:0]              force_idx,
`ifdef SEG_ARB_LOCK_EN
  input  logic [N_SRC-1:0]        lock,
`endif
  output logic [N_SRC-1:0]        grant,
  output logic [N_SRC-1:0]        ack,
  output logic [2:0]              cur_idx,
  output logic                    busy,
  output logic [DATA_W-1:0]       disp_din
);

  localparam int unsigned      CNT_W    = $clog2(DWELL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [2:0]       LAST_RST = 3'(N_SRC - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_FORCE} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [2:0]         last, last_d;
  logic [2:0]         fidx, fidx_d;
  logic [N_SRC-1:0]   grant_d, ack_d;
  logic [2:0]         cur_idx_d;
  logic               busy_d;
  logic [DATA_W-1:0]  disp_d;

  logic [DATA_W-1:0]  words [8];
  logic [7:0]         req8;
  logic [3:0]         pick_idle, pick_exp;
  logic               expire, own_req, own_lock, force_ok, force_req;

  // First set bit of mask searching from base+1 with wrap; bit 3 flags a hit.
  function automatic logic [3:0] rr_pick(input logic [7:0] mask, input logic [2:0] base);
    logic [3:0]  r;
    int unsigned j;
    r = '0;
    for (int unsigned i = 1; i <= N_SRC; i++) begin
      j = (32'(base) + i) % N_SRC;
      if (!r[3] && mask[3'(j)]) r = {1'b1, 3'(j)};
    end
    return r;
  endfunction

  function automatic logic [N_SRC-1:0] onehot(input logic [2:0] idx);
    logic [7:0] v;
    v = 8'b1 << idx;
    return v[N_SRC-1:0];
  endfunction

  // Sources beyond N_SRC read as the idle word so out-of-range indices need no special case.
  for (genvar g = 0; g < 8; g++) begin : g_words
    if (g < N_SRC) begin : g_src
      assign words[g] = data[g*DATA_W +: DATA_W];
    end else begin : g_pad
      assign words[g] = IDLE_VALUE;
    end
  end

  assign req8      = 8'(req);
  assign own_req   = req8[cur_idx];
  assign expire    = (cnt == CNT_LAST);
  assign force_ok  = (32'(force_idx) < N_SRC);
  assign force_req = req8[force_idx];
  assign pick_idle = rr_pick(req8, last);
  assign pick_exp  = rr_pick(req8 & ~(8'b1 << cur_idx), cur_idx);

`ifdef SEG_ARB_LOCK_EN
  logic [7:0] lock8;
  assign lock8    = 8'(lock);
  assign own_lock = lock8[cur_idx];
`else
  assign own_lock = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; the override wins from any state
  always_comb begin
    state_next = state;
    if (force_en) begin
      state_next = S_FORCE;
    end else begin
      case (state)
        S_IDLE:  if (pick_idle[3]) state_next = S_HOLD;
        S_HOLD:  if (expire && !pick_exp[3] && !own_req) state_next = S_IDLE;
        S_FORCE: state_next = force_req ? S_HOLD : S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    grant_d   = grant;
    ack_d     = '0;
    cur_idx_d = cur_idx;
    busy_d    = busy;
    disp_d    = disp_din;
    cnt_d     = cnt;
    last_d    = last;
    fidx_d    = fidx;
    if (force_en) begin
      grant_d   = onehot(force_idx);
      cur_idx_d = force_ok ? force_idx : 3'd0;
      busy_d    = force_ok;
      disp_d    = words[force_idx];
      cnt_d     = '0;
      fidx_d    = force_idx;
      if (state != S_FORCE || force_idx != fidx) ack_d = onehot(force_idx);
    end else begin
      case (state)
        S_IDLE: begin
          grant_d   = '0;
          cur_idx_d = 3'd0;
          busy_d    = 1'b0;
          disp_d    = IDLE_VALUE;
          cnt_d     = '0;
          if (pick_idle[3]) begin
            grant_d   = onehot(pick_idle[2:0]);
            ack_d     = onehot(pick_idle[2:0]);
            cur_idx_d = pick_idle[2:0];
            last_d    = pick_idle[2:0];
            busy_d    = 1'b1;
          end
        end
        S_HOLD: begin
          if (own_req) disp_d = words[cur_idx];
          cnt_d = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
          if (expire) begin
            cnt_d = '0;
            if (own_lock && own_req) begin
              cnt_d = '0;
            end else if (pick_exp[3]) begin
              grant_d   = onehot(pick_exp[2:0]);
              ack_d     = onehot(pick_exp[2:0]);
              cur_idx_d = pick_exp[2:0];
              last_d    = pick_exp[2:0];
            end else if (!own_req) begin
              grant_d   = '0;
              cur_idx_d = 3'd0;
              busy_d    = 1'b0;
              disp_d    = IDLE_VALUE;
            end
          end
        end
        S_FORCE: begin
          cnt_d = '0;
          if (force_req) begin
            grant_d   = onehot(force_idx);
            cur_idx_d = force_idx;
            busy_d    = 1'b1;
            disp_d    = words[force_idx];
          end else begin
            grant_d   = '0;
            cur_idx_d = 3'd0;
            busy_d    = 1'b0;
            disp_d    = IDLE_VALUE;
          end
        end
        default: begin
          grant_d   = '0;
          cur_idx_d = 3'd0;
          busy_d    = 1'b0;
          disp_d    = IDLE_VALUE;
          cnt_d     = '0;
        end
      endcase
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      grant    <= '0;
      ack      <= '0;
      cur_idx  <= 3'd0;
      busy     <= 1'b0;
      disp_din <= IDLE_VALUE;
      cnt      <= '0;
      last     <= LAST_RST;
      fidx     <= 3'd0;
    end else begin
      grant    <= grant_d;
      ack      <= ack_d;
      cur_idx  <= cur_idx_d;
      busy     <= busy_d;
      disp_din <= disp_d;
      cnt      <= cnt_d;
      last     <= last_d;
      fidx     <= fidx_d;
    end
  end

endmodule
